// File: rtl/boot_pkg.sv
// Shared types and constants for the EEPROM boot loader and its I2C bit engine.
package boot_pkg;

   typedef enum logic [3:0] {
      IDLE, START, WR_DEV, WR_ADDR, RESTART, RD_DEV, RD_DATA, STOP, DONE, ERROR
   } boot_state_t;

   typedef enum logic [1:0] {
      CMD_IDLE, CMD_START, CMD_STOP, CMD_BIT
   } phy_cmd_t;

   localparam logic        RW_WRITE   = 1'b0;
   localparam logic        RW_READ    = 1'b1;
   localparam logic [7:0]  START_ADDR = 8'h00;
   localparam int unsigned NUM_BYTES  = 256;
   localparam int unsigned NUM_WORDS  = 64;

   // Returns {scl_oe, sda_oe} for the given command at the start of a quarter.
   function automatic logic [1:0] bus_drive(phy_cmd_t cmd, logic [1:0] quarter, logic bit_val);
      logic [1:0] drv;
      drv = 2'b00;
      case (cmd)
         CMD_START: case (quarter)
            2'd0:    drv = 2'b10;
            2'd1:    drv = 2'b00;
            2'd2:    drv = 2'b01;
            default: drv = 2'b11;
         endcase
         CMD_STOP: case (quarter)
            2'd0:    drv = 2'b11;
            2'd3:    drv = 2'b00;
            default: drv = 2'b01;
         endcase
         CMD_BIT:  drv = {(quarter == 2'd0) || (quarter == 2'd3), ~bit_val};
         default:  drv = 2'b00;
      endcase
      return drv;
   endfunction

endpackage

// File: rtl/i2c_bit_phy.sv
// I2C bit engine: quarter-phase tick divider executing START/STOP/bit commands.
// BOOT_CLK_STRETCH_EN: hold in q1 until the slave releases SCL.
module i2c_bit_phy
   import boot_pkg::*;
#(
   parameter int unsigned CLK_DIV = 125
) (
   input  logic     clk,
   input  logic     rst,
   input  logic     cmd_valid_i,
   input  phy_cmd_t cmd_i,
   input  logic     bit_i,
   input  logic     scl_i,
   input  logic     sda_i,
   output logic     done_o,
   output logic     rd_bit_o,
   output logic     scl_oe_o,
   output logic     sda_oe_o
);

   localparam int unsigned    DW       = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
   localparam logic [DW-1:0]  DIV_LAST = DW'(CLK_DIV - 1);
   localparam logic [DW-1:0]  DIV_END  = DW'(CLK_DIV - 2);

   logic          busy_q, busy_d;
   logic [1:0]    qtr_q, qtr_d;
   logic [DW-1:0] div_q, div_d;
   phy_cmd_t      cmd_q, cmd_d;
   logic          bit_q, bit_d, rd_q, rd_d, scl_q, scl_d, sda_q, sda_d;
   logic          stall, tick, last;

`ifdef BOOT_CLK_STRETCH_EN
   assign stall = busy_q && (qtr_q == 2'd1) && !scl_i;
`else
   logic unused_scl;
   assign unused_scl = scl_i;
   assign stall      = 1'b0;
`endif

   // q3 ends one clock early; the idle cycle that accepts the next command
   // completes it, so back-to-back bits stay exactly 4*CLK_DIV long.
   assign last = busy_q && (qtr_q == 2'd3) && (div_q == DIV_END);
   assign tick = busy_q && (qtr_q != 2'd3) && !stall && (div_q == DIV_LAST);

   always_comb begin
      busy_d = busy_q;
      qtr_d  = qtr_q;
      div_d  = div_q;
      cmd_d  = cmd_q;
      bit_d  = bit_q;
      rd_d   = rd_q;
      scl_d  = scl_q;
      sda_d  = sda_q;
      if (!busy_q) begin
         if (cmd_valid_i) begin
            busy_d         = 1'b1;
            qtr_d          = 2'd0;
            div_d          = '0;
            cmd_d          = cmd_i;
            bit_d          = bit_i;
            {scl_d, sda_d} = bus_drive(cmd_i, 2'd0, bit_i);
         end
      end else if (last) begin
         busy_d = 1'b0;
      end else if (tick) begin
         qtr_d          = qtr_q + 2'd1;
         div_d          = '0;
         {scl_d, sda_d} = bus_drive(cmd_q, qtr_q + 2'd1, bit_q);
         if (qtr_q == 2'd1) rd_d = sda_i;
      end else if (!stall) begin
         div_d = div_q + 1'b1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         busy_q <= 1'b0;
         qtr_q  <= 2'd0;
         div_q  <= '0;
         cmd_q  <= CMD_IDLE;
         bit_q  <= 1'b0;
         rd_q   <= 1'b0;
         scl_q  <= 1'b0;
         sda_q  <= 1'b0;
      end else begin
         busy_q <= busy_d;
         qtr_q  <= qtr_d;
         div_q  <= div_d;
         cmd_q  <= cmd_d;
         bit_q  <= bit_d;
         rd_q   <= rd_d;
         scl_q  <= scl_d;
         sda_q  <= sda_d;
      end
   end

   assign done_o   = last;
   assign rd_bit_o = rd_q;
   assign scl_oe_o = scl_q;
   assign sda_oe_o = sda_q;

endmodule

// File: rtl/boot_loader.sv
// Loads a 256-byte image from an I2C EEPROM into 64 big-endian instruction words.
// BOOT_CLK_STRETCH_EN (in i2c_bit_phy) enables slave clock stretching.
module boot_loader
   import boot_pkg::*;
#(
   parameter int unsigned CLK_DIV   = 125,
   parameter logic [6:0]  DEV_ADDR  = 7'h50,
   parameter int unsigned MAX_RETRY = 3
) (
   input  logic        clk,
   input  logic        rst,
   output logic        scl_oe,
   output logic        sda_oe,
   input  logic        sda_i,
   input  logic        scl_i,
   output logic        wr_en,
   output logic [5:0]  wr_addr,
   output logic [31:0] wr_data,
   output logic        boot_complete,
   output logic        boot_error
);

   localparam int unsigned    BW        = $clog2(NUM_BYTES);
   localparam logic [BW-1:0]  LAST_BYTE = BW'(NUM_BYTES - 1);

   boot_state_t                    state_q, state_d;
   logic [3:0]                     bit_cnt_q, bit_cnt_d;
   logic [BW-1:0]                  byte_cnt_q, byte_cnt_d;
   logic [7:0]                     retry_q, retry_d;
   logic                           nack_q, nack_d;
   logic [31:0]                    shift_q, shift_d;
   logic                           wr_en_q, wr_en_d;
   logic [$clog2(NUM_WORDS)-1:0]   wr_addr_q, wr_addr_d;
   logic [31:0]                    wr_data_q, wr_data_d;
   logic                           complete_q, complete_d, error_q, error_d;

   logic       phy_valid, phy_bit, phy_done, phy_rd;
   phy_cmd_t   phy_cmd;
   logic [7:0] tx_byte;

   i2c_bit_phy #(.CLK_DIV(CLK_DIV)) u_phy (
      .clk         (clk),
      .rst         (rst),
      .cmd_valid_i (phy_valid),
      .cmd_i       (phy_cmd),
      .bit_i       (phy_bit),
      .scl_i       (scl_i),
      .sda_i       (sda_i),
      .done_o      (phy_done),
      .rd_bit_o    (phy_rd),
      .scl_oe_o    (scl_oe),
      .sda_oe_o    (sda_oe)
   );

   always_comb begin
      tx_byte    = 8'hFF;
      phy_cmd    = CMD_BIT;
      phy_valid  = (state_q != DONE) && (state_q != ERROR);
      state_d    = state_q;
      bit_cnt_d  = bit_cnt_q;
      byte_cnt_d = byte_cnt_q;
      retry_d    = retry_q;
      nack_d     = nack_q;
      shift_d    = shift_q;
      wr_en_d    = 1'b0;
      wr_addr_d  = wr_addr_q;
      wr_data_d  = wr_data_q;
      complete_d = complete_q;
      error_d    = error_q;

      case (state_q)
         WR_DEV:  tx_byte = {DEV_ADDR, RW_WRITE};
         WR_ADDR: tx_byte = START_ADDR;
         RD_DEV:  tx_byte = {DEV_ADDR, RW_READ};
         default: tx_byte = 8'hFF;
      endcase
      case (state_q)
         IDLE:           phy_cmd = CMD_IDLE;
         START, RESTART: phy_cmd = CMD_START;
         STOP:           phy_cmd = CMD_STOP;
         default:        phy_cmd = CMD_BIT;
      endcase
      // Ninth bit: released for slave ACK, or master ACK/NACK while reading.
      if (bit_cnt_q[3]) phy_bit = (state_q == RD_DATA) ? (byte_cnt_q == LAST_BYTE) : 1'b1;
      else              phy_bit = tx_byte[3'd7 - bit_cnt_q[2:0]];

      if (phy_done) begin
         case (state_q)
            IDLE:    state_d = START;
            START:   begin state_d = WR_DEV; bit_cnt_d = 4'd0; end
            RESTART: begin state_d = RD_DEV; bit_cnt_d = 4'd0; end
            WR_DEV, WR_ADDR, RD_DEV: begin
               if (!bit_cnt_q[3]) begin
                  bit_cnt_d = bit_cnt_q + 4'd1;
               end else begin
                  bit_cnt_d = 4'd0;
                  if (phy_rd) begin
                     nack_d  = 1'b1;
                     state_d = STOP;
                  end else begin
                     case (state_q)
                        WR_DEV:  state_d = WR_ADDR;
                        WR_ADDR: state_d = RESTART;
                        default: begin state_d = RD_DATA; byte_cnt_d = '0; end
                     endcase
                  end
               end
            end
            RD_DATA: begin
               if (!bit_cnt_q[3]) begin
                  shift_d   = {shift_q[30:0], phy_rd};
                  bit_cnt_d = bit_cnt_q + 4'd1;
               end else begin
                  bit_cnt_d = 4'd0;
                  if (byte_cnt_q[1:0] == 2'd3) begin
                     wr_en_d   = 1'b1;
                     wr_addr_d = byte_cnt_q[BW-1:2];
                     wr_data_d = shift_q;
                  end
                  if (byte_cnt_q == LAST_BYTE) begin
                     nack_d  = 1'b0;
                     state_d = STOP;
                  end else begin
                     byte_cnt_d = byte_cnt_q + 1'b1;
                  end
               end
            end
            STOP: begin
               if (!nack_q) begin
                  state_d    = DONE;
                  complete_d = 1'b1;
               end else if (retry_q == 8'(MAX_RETRY)) begin
                  state_d = ERROR;
                  error_d = 1'b1;
               end else begin
                  retry_d    = retry_q + 8'd1;
                  byte_cnt_d = '0;
                  nack_d     = 1'b0;
                  state_d    = START;
               end
            end
            default: state_d = state_q;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= IDLE;
         bit_cnt_q  <= 4'd0;
         byte_cnt_q <= '0;
         retry_q    <= 8'd0;
         nack_q     <= 1'b0;
         shift_q    <= '0;
         wr_en_q    <= 1'b0;
         wr_addr_q  <= '0;
         wr_data_q  <= '0;
         complete_q <= 1'b0;
         error_q    <= 1'b0;
      end else begin
         state_q    <= state_d;
         bit_cnt_q  <= bit_cnt_d;
         byte_cnt_q <= byte_cnt_d;
         retry_q    <= retry_d;
         nack_q     <= nack_d;
         shift_q    <= shift_d;
         wr_en_q    <= wr_en_d;
         wr_addr_q  <= wr_addr_d;
         wr_data_q  <= wr_data_d;
         complete_q <= complete_d;
         error_q    <= error_d;
      end
   end

   assign wr_en         = wr_en_q;
   assign wr_addr       = wr_addr_q;
   assign wr_data       = wr_data_q;
   assign boot_complete = complete_q;
   assign boot_error    = error_q;

endmodule

// File: tb/tb_boot_loader.sv
// Bench for boot_loader: EEPROM bus model plus write-port and bus-event scoreboards.
module tb_boot_loader;

   localparam int unsigned CLK_DIV  = 2;
   localparam logic [8:0]  EV_START = 9'h100;
   localparam logic [8:0]  EV_STOP  = 9'h101;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        scl_oe, sda_oe, sda_i, scl_i, wr_en, boot_complete, boot_error;
   logic [5:0]  wr_addr;
   logic [31:0] wr_data;
   logic        slave_low = 1'b0;
   int          hold_cnt  = 0;

   assign scl_i = !scl_oe && (hold_cnt == 0);
   assign sda_i = !sda_oe && !slave_low;

   always #5 clk = ~clk;

   boot_loader #(.CLK_DIV(CLK_DIV), .DEV_ADDR(7'h50), .MAX_RETRY(3)) dut (
      .clk           (clk),
      .rst           (rst),
      .scl_oe        (scl_oe),
      .sda_oe        (sda_oe),
      .sda_i         (sda_i),
      .scl_i         (scl_i),
      .wr_en         (wr_en),
      .wr_addr       (wr_addr),
      .wr_data       (wr_data),
      .boot_complete (boot_complete),
      .boot_error    (boot_error)
   );

   int n_vec = 0, n_err = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // write-port scoreboard
   logic [37:0] sb_q[$];
   logic [31:0] got_word[64];
   int          n_wr = 0;

   always @(negedge clk) begin
      if (!rst && wr_en) begin
         n_wr++;
         if (sb_q.size() == 0) begin
            chk("wr_extra_addr", 64'(wr_addr), 64'h40);
         end else begin
            logic [37:0] e;
            e = sb_q.pop_front();
            chk("wr_addr", 64'(wr_addr), 64'(e[37:32]));
            chk("wr_data", 64'(wr_data), 64'(e[31:0]));
         end
         got_word[wr_addr] = wr_data;
      end
   end

   // EEPROM model, mem[i] = i; compares observed bus events against bus_q
   logic [8:0] bus_q[$];
   int         bitpos = 0, k = 0, ptr = 0, since_rise = 0;
   int         n_start = 0, n_stop = 0, n_nacked = 0, nack_mode = 0;
   logic [7:0] rx = 8'h00, tx = 8'h00;
   bit         in_read = 0, master_nack = 0, bus_chk = 0, stretch_en = 0;
   logic       prev_scl = 1'b1, prev_sda = 1'b1;

   task automatic emit(input logic [8:0] ev);
      if (bus_chk) begin
         if (bus_q.size() == 0) chk("bus_extra", 64'(ev), 64'h1FF);
         else                   chk("bus_event", 64'(ev), 64'(bus_q.pop_front()));
      end
   endtask

   always @(negedge clk) begin
      logic scl, sda, nack;
      scl = scl_i;
      sda = sda_i;
      if (rst) begin
         bitpos = 0; k = 0; in_read = 0; slave_low = 1'b0; hold_cnt = 0;
         prev_scl = 1'b1; prev_sda = 1'b1;
      end else begin
         if (hold_cnt > 0) hold_cnt--;
         since_rise++;
         if (prev_scl && scl && prev_sda && !sda) begin
            n_start++; emit(EV_START);
            bitpos = 0; k = 0; in_read = 0; slave_low = 1'b0;
         end else if (prev_scl && scl && !prev_sda && sda) begin
            n_stop++; emit(EV_STOP);
            bitpos = 0; k = 0; in_read = 0; slave_low = 1'b0;
         end else if (!prev_scl && scl) begin
            if (bitpos < 8) begin
               rx = {rx[6:0], sda};
               if (in_read && k >= 1 && ptr == 1 && bitpos >= 1)
                  chk("scl_period", 64'(since_rise), 64'(4 * CLK_DIV));
            end else if (in_read && k >= 1) begin
               chk("master_ack", 64'(sda), 64'(ptr - 1 == 255));
               if (stretch_en && ptr == 11) chk("stretch_wait", 64'(since_rise >= 1000), 64'd1);
               master_nack = sda;
            end
            since_rise = 0;
            bitpos++;
         end else if (prev_scl && !scl) begin
            if (bitpos >= 1 && bitpos <= 7) begin
               if (in_read && k >= 1) slave_low = !tx[7 - bitpos];
            end else if (bitpos == 8) begin
               if (!(in_read && k >= 1)) begin
                  emit({1'b0, rx});
                  nack = (k == 0) && (rx == 8'hA0) &&
                         (nack_mode == 2 || (nack_mode == 1 && n_nacked == 0));
                  if (nack) n_nacked++;
                  if (k == 1) ptr = int'(rx);
                  slave_low = !nack;
               end else begin
                  slave_low = 1'b0;
                  if (stretch_en && ptr == 11) hold_cnt = 1000;
               end
            end else if (bitpos == 9) begin
               bitpos = 0;
               k++;
               if (k == 1 && rx[0]) in_read = 1;
               if (in_read && (k == 1 || !master_nack)) begin
                  tx = ptr[7:0]; ptr++;
                  slave_low = !tx[7];
               end else begin
                  slave_low = 1'b0;
               end
            end
         end
         prev_scl = scl_i;
         prev_sda = sda_i;
      end
   end

   task automatic push_words(input int n);
      for (int w = 0; w < n; w++)
         sb_q.push_back({6'(w), 8'(4*w), 8'(4*w + 1), 8'(4*w + 2), 8'(4*w + 3)});
   endtask

   task automatic push_load_events();
      bus_q.push_back(EV_START); bus_q.push_back(9'h0A0); bus_q.push_back(9'h000);
      bus_q.push_back(EV_START); bus_q.push_back(9'h0A1); bus_q.push_back(EV_STOP);
   endtask

   task automatic prep(input int nm);
      rst = 1'b1;
      repeat (3) @(negedge clk);
      nack_mode = nm; n_start = 0; n_stop = 0; n_nacked = 0; n_wr = 0;
      stretch_en = 0; bus_chk = 1; master_nack = 0;
   endtask

   task automatic wait_end(input string name);
      for (int c = 0; c < 30000; c++) begin
         @(negedge clk);
         if (boot_complete || boot_error) break;
      end
      chk(name, 64'(boot_complete || boot_error), 64'd1);
   endtask

   task automatic check_load_ok(input string tag);
      wait_end({tag, "_timeout"});
      repeat (40) @(negedge clk);
      chk({tag, "_complete"}, 64'(boot_complete), 64'd1);
      chk({tag, "_error"}, 64'(boot_error), 64'd0);
      chk({tag, "_bus_released"}, 64'({scl_oe, sda_oe}), 64'd0);
      chk({tag, "_wr_count"}, 64'(n_wr), 64'd64);
      chk({tag, "_word0"}, 64'(got_word[0]), 64'h00010203);
      chk({tag, "_word63"}, 64'(got_word[63]), 64'hFCFDFEFF);
      chk({tag, "_sb_left"}, 64'(sb_q.size()), 64'd0);
      chk({tag, "_bus_left"}, 64'(bus_q.size()), 64'd0);
   endtask

   initial begin
      bit hit;
      rst = 1'b1;
      repeat (5) @(negedge clk);
      chk("rst_scl_oe", 64'(scl_oe), 64'd0);
      chk("rst_sda_oe", 64'(sda_oe), 64'd0);
      chk("rst_wr_en", 64'(wr_en), 64'd0);
      chk("rst_wr_addr", 64'(wr_addr), 64'd0);
      chk("rst_wr_data", 64'(wr_data), 64'd0);
      chk("rst_complete", 64'(boot_complete), 64'd0);
      chk("rst_error", 64'(boot_error), 64'd0);

      // reset asserted in the middle of data byte 100
      prep(0);
      bus_chk = 0;
      push_words(25);
      rst = 1'b0;
      hit = 0;
      for (int c = 0; c < 30000; c++) begin
         @(negedge clk);
         if (ptr == 101 && bitpos == 4 && in_read) begin hit = 1; break; end
      end
      chk("byte100_reached", 64'(hit), 64'd1);
      rst = 1'b1;
      #1;
      chk("midrst_scl_oe", 64'(scl_oe), 64'd0);
      chk("midrst_sda_oe", 64'(sda_oe), 64'd0);
      chk("midrst_wr_en", 64'(wr_en), 64'd0);
      chk("midrst_complete", 64'(boot_complete), 64'd0);
      repeat (3) @(negedge clk);
      chk("midrst_sb_drained", 64'(sb_q.size()), 64'd0);

      // full load after reset, with byte-level bus checks
      prep(0);
      push_words(64);
      push_load_events();
      rst = 1'b0;
      check_load_ok("load");
      chk("load_starts", 64'(n_start), 64'd2);

      // device address NACKed on the first attempt only
      prep(1);
      push_words(64);
      bus_q.push_back(EV_START); bus_q.push_back(9'h0A0); bus_q.push_back(EV_STOP);
      push_load_events();
      rst = 1'b0;
      check_load_ok("retry");
      chk("retry_stops", 64'(n_stop), 64'd2);

      // device always NACKs
      prep(2);
      for (int a = 0; a < 4; a++) begin
         bus_q.push_back(EV_START); bus_q.push_back(9'h0A0); bus_q.push_back(EV_STOP);
      end
      rst = 1'b0;
      wait_end("nack_timeout");
      repeat (200) @(negedge clk);
      chk("nack_starts", 64'(n_start), 64'd4);
      chk("nack_error", 64'(boot_error), 64'd1);
      chk("nack_complete", 64'(boot_complete), 64'd0);
      chk("nack_bus_released", 64'({scl_oe, sda_oe}), 64'd0);
      chk("nack_wr_count", 64'(n_wr), 64'd0);
      chk("nack_bus_left", 64'(bus_q.size()), 64'd0);

`ifdef BOOT_CLK_STRETCH_EN
      // slave stretches SCL during the ACK of byte 10
      prep(0);
      stretch_en = 1;
      push_words(64);
      push_load_events();
      rst = 1'b0;
      check_load_ok("stretch");
`endif

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
